// File: rtl/rho_inv_if.sv
// Handshake and data bundle for rho_inv_seq. The mode signal exists only when RHO_INV_FWD_EN is defined.
interface rho_inv_if;
  logic          in_valid;
  logic          in_ready;
  logic [1599:0] in_state;
  logic          out_valid;
  logic          out_ready;
  logic [1599:0] out_state;
  logic          busy;
`ifdef RHO_INV_FWD_EN
  logic          mode;
`endif

  modport master (
    output in_valid, in_state, out_ready,
`ifdef RHO_INV_FWD_EN
    output mode,
`endif
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready,
`ifdef RHO_INV_FWD_EN
    input  mode,
`endif
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/rho_inv_seq.sv
// Lane-serial Keccak inverse rho: one lane per cycle through a shared 64-bit rotator.
// Defining RHO_INV_FWD_EN adds a captured mode bit selecting forward rho (left rotate).
//   state | meaning
//   IDLE  | waiting for a state, in_ready high
//   RUN   | rotating lane k, k = 0..24
//   DONE  | result held until out_ready
module rho_inv_seq (
  input logic      clk,
  input logic      rst,
  rho_inv_if.slave s
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    k_q, k_d;
  logic [1599:0] buf_q, buf_d;
`ifdef RHO_INV_FWD_EN
  logic          mode_q, mode_d;
`endif

  logic [63:0] lane;
  logic [63:0] lane_rot;
  logic [5:0]  r;
  logic [6:0]  shamt;

  function automatic logic [5:0] rho_off(input logic [4:0] k);
    case (k)
      5'd0:  rho_off = 6'd0;   5'd1:  rho_off = 6'd1;   5'd2:  rho_off = 6'd62;
      5'd3:  rho_off = 6'd28;  5'd4:  rho_off = 6'd27;  5'd5:  rho_off = 6'd36;
      5'd6:  rho_off = 6'd44;  5'd7:  rho_off = 6'd6;   5'd8:  rho_off = 6'd55;
      5'd9:  rho_off = 6'd20;  5'd10: rho_off = 6'd3;   5'd11: rho_off = 6'd10;
      5'd12: rho_off = 6'd43;  5'd13: rho_off = 6'd25;  5'd14: rho_off = 6'd39;
      5'd15: rho_off = 6'd41;  5'd16: rho_off = 6'd45;  5'd17: rho_off = 6'd15;
      5'd18: rho_off = 6'd21;  5'd19: rho_off = 6'd8;   5'd20: rho_off = 6'd18;
      5'd21: rho_off = 6'd2;   5'd22: rho_off = 6'd61;  5'd23: rho_off = 6'd56;
      5'd24: rho_off = 6'd14;
      default: rho_off = 6'd0;
    endcase
  endfunction

  // Left rotate by r is a right rotate by 64-r; shamt=64 degenerates to identity.
  always_comb begin
    lane  = buf_q[{k_q, 6'd0} +: 64];
    r     = rho_off(k_q);
    shamt = {1'b0, r};
`ifdef RHO_INV_FWD_EN
    if (mode_q) shamt = 7'd64 - {1'b0, r};
`endif
    lane_rot = (lane >> shamt) | (lane << (7'd64 - shamt));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    buf_d   = buf_q;
`ifdef RHO_INV_FWD_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (s.in_valid) begin
          buf_d   = s.in_state;
          k_d     = 5'd0;
          state_d = RUN;
`ifdef RHO_INV_FWD_EN
          mode_d  = s.mode;
`endif
        end
      end
      RUN: begin
        buf_d[{k_q, 6'd0} +: 64] = lane_rot;
        if (k_q == 5'd24) begin
          k_d     = 5'd0;
          state_d = DONE;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      DONE: begin
        if (s.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 5'd0;
      buf_q   <= '0;
`ifdef RHO_INV_FWD_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
`ifdef RHO_INV_FWD_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign s.in_ready  = (state_q == IDLE);
  assign s.out_valid = (state_q == DONE);
  assign s.busy      = (state_q != IDLE);
  assign s.out_state = buf_q;
endmodule

// File: tb/tb_rho_inv_seq.sv
// Scoreboard bench for rho_inv_seq: stimulus pushes expected results, a monitor pops on handshake.
module tb_rho_inv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  rho_inv_if bus ();
  rho_inv_seq u_dut (.clk(clk), .rst(rst), .s(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1599:0] exp;
    int            cap;
  } item_t;

  item_t q[$];
  int    rise_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  int roff [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                    41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  function automatic logic [63:0] rotr_m(input logic [63:0] v, input int r);
    logic [63:0] o;
    for (int z = 0; z < 64; z++) o[z] = v[(z + r) % 64];
    return o;
  endfunction

  function automatic logic [63:0] rotl_m(input logic [63:0] v, input int r);
    logic [63:0] o;
    for (int z = 0; z < 64; z++) o[(z + r) % 64] = v[z];
    return o;
  endfunction

  function automatic logic [1599:0] inv_m(input logic [1599:0] st);
    logic [1599:0] o;
    for (int k = 0; k < 25; k++) o[64*k +: 64] = rotr_m(st[64*k +: 64], roff[k]);
    return o;
  endfunction

  function automatic logic [1599:0] fwd_m(input logic [1599:0] st);
    logic [1599:0] o;
    for (int k = 0; k < 25; k++) o[64*k +: 64] = rotl_m(st[64*k +: 64], roff[k]);
    return o;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] o;
    for (int i = 0; i < 50; i++) o[32*i +: 32] = $urandom;
    return o;
  endfunction

  task automatic chk_vec(input string nm, input logic [1599:0] act, input logic [1599:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int k = 0; k < 25; k++)
        if (act[64*k +: 64] !== exp[64*k +: 64]) begin
          $display("FAIL %s lane %0d got %h want %h (t=%0t)", nm, k,
                   act[64*k +: 64], exp[64*k +: 64], $time);
          break;
        end
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor samples just before each rising edge, seeing what the DUT will act on.
  logic prev_v = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (bus.out_valid && !prev_v) begin
          rise_q.push_back(cyc);
          if (q.size() == 0) begin
            chk_int("unexpected_out_valid", 1, 0);
          end else begin
            chk_int("latency", cyc - q[0].cap + 1, 26);
          end
        end
        if (bus.out_valid && bus.out_ready && q.size() != 0) begin
          item_t it;
          it = q.pop_front();
          chk_vec("out_state", bus.out_state, it.exp);
        end
      end
      prev_v = rst ? 1'b0 : bus.out_valid;
    end
  end

  // Caller is at a negedge; returns at the negedge following the capture edge.
  task automatic send(input logic [1599:0] st, input logic [1599:0] exp,
                      input bit push, input bit keep_valid);
    int w;
    bus.in_state = st;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk_int("in_ready_timeout", 0, 1);
    if (push) q.push_back('{exp, cyc + 1});
    @(negedge clk);
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || !bus.in_ready) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk_int("drain_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1599:0] a, b, st, exp;
    logic [1599:0] strm [4];

    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.out_ready = 1'b1;
`ifdef RHO_INV_FWD_EN
    bus.mode      = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_int("rst_in_ready", int'(bus.in_ready), 1);
    chk_int("rst_out_valid", int'(bus.out_valid), 0);
    chk_int("rst_busy", int'(bus.busy), 0);
    chk_vec("rst_out_state", bus.out_state, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single-bit inverse, hand-computed result
    st = '0; st[64 +: 64] = 64'h1;
    exp = '0; exp[64 +: 64] = 64'h8000_0000_0000_0000;
    send(st, exp, 1, 0);
    chk_int("busy_in_run", int'(bus.busy), 1);
    chk_int("in_ready_in_run", int'(bus.in_ready), 0);
    drain();

    // Lane (0,0) untouched; lane (2,0) bit 0 -> rotate right 62 -> bit 2
    st = '0; st[63:0] = 64'hDEAD_BEEF_0123_4567; st[128 +: 64] = 64'h1;
    exp = '0; exp[63:0] = 64'hDEAD_BEEF_0123_4567; exp[128 +: 64] = 64'h4;
    send(st, exp, 1, 0);
    drain();

    // Every lane bit 0 set; lane (4,4) r=14 -> bit 50
    st = '0; for (int k = 0; k < 25; k++) st[64*k] = 1'b1;
    exp = inv_m(st);
    chk_int("hand_lane24", int'(exp[64*24 + 50]), 1);
    send(st, exp, 1, 0);
    drain();

    // Backpressure: result held, second state ignored
    a = rand_state(); b = rand_state();
    bus.out_ready = 1'b0;
    send(fwd_m(a), a, 1, 0);
    begin
      int w;
      w = 0;
      while (!bus.out_valid && w < 100) begin @(negedge clk); w++; end
      if (w >= 100) chk_int("bp_valid_timeout", 0, 1);
    end
    bus.in_state = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_vec("bp_hold", bus.out_state, a);
      chk_int("bp_in_ready", int'(bus.in_ready), 0);
      chk_int("bp_out_valid", int'(bus.out_valid), 1);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_int("bp_release_in_ready", int'(bus.in_ready), 1);
    chk_int("bp_release_out_valid", int'(bus.out_valid), 0);
    repeat (40) @(negedge clk);
    chk_int("bp_no_second", q.size(), 0);

    // Reset during RUN at lane 12
    send(rand_state(), '0, 0, 0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_int("midrst_in_ready", int'(bus.in_ready), 1);
    chk_int("midrst_out_valid", int'(bus.out_valid), 0);
    chk_int("midrst_busy", int'(bus.busy), 0);
    chk_vec("midrst_out_state", bus.out_state, '0);
    repeat (60) @(negedge clk);

    // Streaming with in_valid held high
    for (int i = 0; i < 4; i++) strm[i] = rand_state();
    rise_q.delete();
    for (int i = 0; i < 4; i++) send(fwd_m(strm[i]), strm[i], 1, 1);
    bus.in_valid = 1'b0;
    drain();
    chk_int("stream_count", rise_q.size(), 4);
    if (rise_q.size() == 4)
      for (int i = 1; i < 4; i++) chk_int("stream_gap", rise_q[i] - rise_q[i-1], 27);

`ifdef RHO_INV_FWD_EN
    st = '0; st[64 +: 64] = 64'h8000_0000_0000_0000;
    exp = '0; exp[64 +: 64] = 64'h1;
    bus.mode = 1'b1;
    send(st, exp, 1, 0);
    bus.mode = 1'b0;
    drain();
    a = rand_state();
    bus.mode = 1'b1;
    send(a, fwd_m(a), 1, 0);
    bus.mode = 1'b0;
    drain();
`endif

    // Round trip through the bench's forward rho
    for (int i = 0; i < 1000; i++) begin
      a = rand_state();
      send(fwd_m(a), a, 1, 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
